// File: rtl/layer2_window_reader_pkg.sv
// Shared types and constants for the layer-2 window reader.
package layer2_window_reader_pkg;
  `include "def.svh"

  localparam int KERNEL       = 3;
  localparam int WINDOW_SLOTS = KERNEL * KERNEL;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Row offset of slot k inside the 3x3 window.
  function automatic logic [15:0] k_row(input logic [3:0] k);
    return 16'(k / 4'd3);
  endfunction

  // Column offset of slot k inside the 3x3 window.
  function automatic logic [15:0] k_col(input logic [3:0] k);
    return 16'(k % 4'd3);
  endfunction
endpackage

// File: rtl/def.svh
// Shared layer sizing constants for the layer pipeline.
`ifndef DEF_SVH
`define DEF_SVH
localparam int LAYER2_OUTPUT_LENGTH = 8;
localparam int LAYER3_WIDTH = 5;
`endif

// File: rtl/layer2_window_counter.sv
// Window position (out_row, out_col) and in-window slot index k.
module layer2_window_counter
  import layer2_window_reader_pkg::*;
#(
  parameter int WIDTH = LAYER3_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        advance_k,
  input  logic        advance_window,
  output logic [15:0] out_row,
  output logic [15:0] out_col,
  output logic [3:0]  k,
  output logic        last_k,
  output logic        last_window
);
  // Last valid top-left coordinate of a 3x3 window without padding.
  localparam logic [15:0] LAST_POS = 16'(WIDTH - KERNEL);

  assign last_k      = (k == 4'(WINDOW_SLOTS - 1));
  assign last_window = (out_row == LAST_POS) && (out_col == LAST_POS);

  // Slot index walks 0..8 then wraps for the next window.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      k <= '0;
    end else if (advance_k) begin
      k <= last_k ? 4'd0 : k + 4'd1;
    end
  end

  // Raster-order window position: columns first, then wrap to next row.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      out_row <= '0;
      out_col <= '0;
    end else if (advance_window) begin
      if (out_col < LAST_POS) begin
        out_col <= out_col + 16'd1;
      end else begin
        out_col <= '0;
        if (out_row < LAST_POS) begin
          out_row <= out_row + 16'd1;
        end
      end
    end
  end
endmodule

// File: rtl/layer2_window_reader.sv
// Walks the layer-2 result map, gathers 3x3 windows and hands them to layer 3.
module layer2_window_reader
  import layer2_window_reader_pkg::*;
#(
  parameter int DATA_W = LAYER2_OUTPUT_LENGTH,
  parameter int WIDTH  = LAYER3_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [15:0]                read_row_addr,
  output logic [15:0]                read_col_addr,
  output logic                       layer2_result_read_signal,
  input  logic [DATA_W-1:0]          layer2_result_output,
  output logic [WINDOW_SLOTS*DATA_W-1:0] window_data,
  output logic                       window_valid,
  input  logic                       window_ready,
  output logic                       busy,
  output logic                       done
);
  state_t      state_reg, state_next;
  logic [15:0] out_row, out_col;
  logic [3:0]  k;
  logic        last_k, last_window;
  logic        fetching, handshake, clear_counters;

  assign fetching       = (state_reg == FETCH);
  assign handshake      = (state_reg == HOLD) && window_ready;
  assign clear_counters = (state_reg == IDLE) && start;

  layer2_window_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear_counters),
    .advance_k      (fetching),
    .advance_window (handshake),
    .out_row        (out_row),
    .out_col        (out_col),
    .k              (k),
    .last_k         (last_k),
    .last_window    (last_window)
  );

  // Next-state selection; start is only honoured from IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (last_k) state_next = HOLD;
      HOLD:    if (window_ready) state_next = last_window ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Memory address is the window origin plus the slot offset; zero when idle.
  assign read_row_addr             = fetching ? out_row + k_row(k) : 16'd0;
  assign read_col_addr             = fetching ? out_col + k_col(k) : 16'd0;
  assign layer2_result_read_signal = fetching;

  assign window_valid = (state_reg == HOLD);
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);

  // One register per slot; each captures memory data when its k is fetched.
  generate
    for (genvar gi = 0; gi < WINDOW_SLOTS; gi++) begin : g_slot
      logic [DATA_W-1:0] slot_reg;

      // Slot capture; contents persist until overwritten by the next window.
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (fetching && (k == 4'(gi))) begin
          slot_reg <= layer2_result_output;
        end
      end

      assign window_data[gi*DATA_W +: DATA_W] = slot_reg;
    end
  endgenerate
endmodule

// File: tb/tb_layer2_window_reader.sv
// Directed bench for layer2_window_reader with a 5x5 map, mem[r][c] = 16*r + c.
module tb_layer2_window_reader;
  localparam int DW = 8;
  localparam int W  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   read_row_addr, read_col_addr;
  logic          rd;
  logic [DW-1:0] mem_q;
  logic [9*DW-1:0] window_data;
  logic          window_valid, window_ready, busy, done;

  logic [7:0] mem [0:W-1][0:W-1];
  int checks = 0;
  int passed = 0;
  int cyc;

  // Hand-computed window contents, slot 0 in the low byte.
  localparam logic [71:0] WIN_00 = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] WIN_01 = 72'h23_22_21_13_12_11_03_02_01;
  localparam logic [71:0] WIN_10 = 72'h32_31_30_22_21_20_12_11_10;

  always #5 clk = ~clk;

  // Combinational memory read model.
  always_comb begin
    mem_q = '0;
    if (read_row_addr < 16'(W) && read_col_addr < 16'(W))
      mem_q = mem[read_row_addr[2:0]][read_col_addr[2:0]];
  end

  layer2_window_reader #(
    .DATA_W (DW),
    .WIDTH  (W)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .read_row_addr             (read_row_addr),
    .read_col_addr             (read_col_addr),
    .layer2_result_read_signal (rd),
    .layer2_result_output      (mem_q),
    .window_data               (window_data),
    .window_valid              (window_valid),
    .window_ready              (window_ready),
    .busy                      (busy),
    .done                      (done)
  );

  function automatic logic [71:0] exp_window(input int r, input int c);
    logic [71:0] v;
    v = '0;
    for (int s = 0; s < 9; s++)
      v[s*8 +: 8] = 8'(16 * (r + s / 3) + c + s % 3);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; window_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Start sampled at edge 0; returns in cycle 1.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; window_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({read_row_addr, read_col_addr, rd, window_data, window_valid, busy, done} !== '0)
        $display("FAIL reset_idle cycle %0d: got addr=%0d,%0d rd=%b data=%h valid=%b busy=%b done=%b, want all 0",
                 i, read_row_addr, read_col_addr, rd, window_data, window_valid, busy, done);
      else passed++;
    end
    $display("test_reset: 20 idle cycles observed");
  endtask

  task automatic test_first_window();
    do_reset();
    window_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (rd !== 1'b1 || window_valid !== 1'b0 || busy !== 1'b1 ||
          read_row_addr !== 16'(k / 3) || read_col_addr !== 16'(k % 3))
        $display("FAIL first_fetch k=%0d: got rd=%b valid=%b busy=%b addr=(%0d,%0d), want rd=1 valid=0 busy=1 addr=(%0d,%0d)",
                 k, rd, window_valid, busy, read_row_addr, read_col_addr, k / 3, k % 3);
      else passed++;
      tick();
    end
    checks++;
    if (window_valid !== 1'b1 || rd !== 1'b0)
      $display("FAIL first_valid cycle %0d: got valid=%b rd=%b, want valid=1 rd=0", cyc, window_valid, rd);
    else passed++;
    checks++;
    if (window_data !== WIN_00)
      $display("FAIL first_data: got %h, want %h", window_data, WIN_00);
    else passed++;
    $display("test_first_window: window (0,0) data=%h", window_data);
  endtask

  task automatic test_full_scan();
    int nwin, done_cnt, done_cyc;
    logic [7:0] last_slot8;
    do_reset();
    window_ready = 1'b1;
    pulse_start();
    nwin = 0; done_cnt = 0; done_cyc = -1; last_slot8 = '0;
    while (cyc <= 120) begin
      if (window_valid && window_ready) begin
        checks++;
        if (window_data !== exp_window(nwin / 3, nwin % 3))
          $display("FAIL scan_window %0d: got %h, want %h", nwin, window_data, exp_window(nwin / 3, nwin % 3));
        else passed++;
        $display("scan window %0d at (%0d,%0d) cycle %0d data=%h", nwin, nwin / 3, nwin % 3, cyc, window_data);
        last_slot8 = window_data[71:64];
        nwin++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      tick();
    end
    checks++;
    if (nwin !== 9) $display("FAIL scan_count: got %0d windows, want 9", nwin);
    else passed++;
    checks++;
    if (last_slot8 !== 8'h44) $display("FAIL scan_last_slot8: got %h, want 44", last_slot8);
    else passed++;
    checks++;
    if (done_cnt !== 1) $display("FAIL scan_done_count: got %0d, want 1", done_cnt);
    else passed++;
    checks++;
    if (done_cyc !== 91) $display("FAIL scan_done_cycle: got %0d, want 91", done_cyc);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL scan_busy_after: got %b, want 0", busy);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    window_ready = 1'b1;
    pulse_start();
    while (cyc < 19) tick();
    window_ready = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (window_valid !== 1'b1 || rd !== 1'b0 || window_data !== WIN_01)
        $display("FAIL backpressure_hold cycle %0d: got valid=%b rd=%b data=%h, want valid=1 rd=0 data=%h",
                 cyc, window_valid, rd, window_data, WIN_01);
      else passed++;
      if (i < 6) tick();
    end
    window_ready = 1'b1;
    tick();
    checks++;
    if (rd !== 1'b1 || window_valid !== 1'b0 || read_row_addr !== 16'd0 || read_col_addr !== 16'd2)
      $display("FAIL backpressure_release: got rd=%b valid=%b addr=(%0d,%0d), want rd=1 valid=0 addr=(0,2)",
               rd, window_valid, read_row_addr, read_col_addr);
    else passed++;
    $display("test_backpressure: released at cycle %0d", cyc);
  endtask

  task automatic test_row_wrap();
    do_reset();
    window_ready = 1'b1;
    pulse_start();
    while (cyc < 30) tick();
    checks++;
    if (window_valid !== 1'b1 || window_data[7:0] !== 8'h02)
      $display("FAIL wrap_prev: got valid=%b slot0=%h, want valid=1 slot0=02", window_valid, window_data[7:0]);
    else passed++;
    while (cyc < 40) tick();
    checks++;
    if (window_valid !== 1'b1 || window_data !== WIN_10)
      $display("FAIL wrap_next: got valid=%b data=%h, want valid=1 data=%h", window_valid, window_data, WIN_10);
    else passed++;
    $display("test_row_wrap: window (1,0) data=%h", window_data);
  endtask

  task automatic test_midscan();
    int done_seen;
    do_reset();
    window_ready = 1'b1;
    pulse_start();
    while (cyc < 3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (rd !== 1'b1 || read_row_addr !== 16'd1 || read_col_addr !== 16'd0)
      $display("FAIL ignored_start: got rd=%b addr=(%0d,%0d), want rd=1 addr=(1,0)", rd, read_row_addr, read_col_addr);
    else passed++;
    while (cyc < 33) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({read_row_addr, read_col_addr, rd, window_data, window_valid, busy, done} !== '0)
      $display("FAIL midscan_reset: got addr=(%0d,%0d) rd=%b data=%h valid=%b busy=%b done=%b, want all 0",
               read_row_addr, read_col_addr, rd, window_data, window_valid, busy, done);
    else passed++;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) done_seen++;
      tick();
    end
    checks++;
    if (done_seen !== 0) $display("FAIL midscan_quiet: got %0d active cycles, want 0", done_seen);
    else passed++;
    pulse_start();
    while (cyc < 10) tick();
    checks++;
    if (window_valid !== 1'b1 || window_data !== WIN_00)
      $display("FAIL restart_window: got valid=%b data=%h, want valid=1 data=%h", window_valid, window_data, WIN_00);
    else passed++;
    $display("test_midscan: restart window data=%h", window_data);
  endtask

  initial begin
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        mem[r][c] = 8'(16 * r + c);
    cyc = 0;
    rst = 1'b1; start = 1'b0; window_ready = 1'b0;
    test_reset();
    test_first_window();
    test_full_scan();
    test_backpressure();
    test_row_wrap();
    test_midscan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d checks=%0d", passed, checks);
    $fatal(1, "watchdog");
  end
endmodule
